// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the CPU core memory ports, mem_bus_arbiter and the shared memory bus.
// The master modport is the arbiter's view. The slave modport is the view of the core and memory around it.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Core instruction port
    logic [ADDR_W-1:0] instr_mem_addr_i;
    logic              instr_mem_rd_i;
    logic              instr_mem_ready_o;
    logic [DATA_W-1:0] instr_mem_data_o;

    // Core data port
    logic [ADDR_W-1:0] data_mem_addr_i;
    logic [DATA_W-1:0] data_mem_data_i;
    logic              data_mem_rd_i;
    logic              data_mem_wr_i;
    logic              data_mem_ready_o;
    logic [DATA_W-1:0] data_mem_data_o;

    // Shared single-port memory bus
    logic              bus_req_o;
    logic              bus_we_o;
    logic [ADDR_W-1:0] bus_addr_o;
    logic [DATA_W-1:0] bus_wdata_o;
    logic              bus_ack_i;
    logic [DATA_W-1:0] bus_rdata_i;

    logic              err_o;

    modport master (
        input  instr_mem_addr_i,
        input  instr_mem_rd_i,
        output instr_mem_ready_o,
        output instr_mem_data_o,
        input  data_mem_addr_i,
        input  data_mem_data_i,
        input  data_mem_rd_i,
        input  data_mem_wr_i,
        output data_mem_ready_o,
        output data_mem_data_o,
        output bus_req_o,
        output bus_we_o,
        output bus_addr_o,
        output bus_wdata_o,
        input  bus_ack_i,
        input  bus_rdata_i,
        output err_o
    );

    modport slave (
        output instr_mem_addr_i,
        output instr_mem_rd_i,
        input  instr_mem_ready_o,
        input  instr_mem_data_o,
        output data_mem_addr_i,
        output data_mem_data_i,
        output data_mem_rd_i,
        output data_mem_wr_i,
        input  data_mem_ready_o,
        input  data_mem_data_o,
        input  bus_req_o,
        input  bus_we_o,
        input  bus_addr_o,
        input  bus_wdata_o,
        output bus_ack_i,
        output bus_rdata_i,
        input  err_o
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Serves the core's data and instruction ports over one shared bus. Each pipeline step runs as: optional data access, fetch, then one ready pulse.
// An optional ack watchdog substitutes data and raises a sticky error flag when the slave stops responding.
module mem_bus_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    mem_bus_arbiter_if.master mem
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DATA  = 2'd1;
    localparam logic [1:0] ST_INSTR = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam bit                WD_EN    = (TIMEOUT_CYC > 0);
    localparam int                CNT_W    = WD_EN ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = WD_EN ? CNT_W'(TIMEOUT_CYC - 1) : '0;
    localparam logic [DATA_W-1:0] NOP_INSN = DATA_W'(32'h0000_0013);

    logic [1:0]        state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] load_q, load_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              ack;
    logic              timeout;
    logic              xfer_done;
    logic [CNT_W-1:0]  cnt_inc;

    // An ack in the terminal-count cycle completes the transfer normally, so ack masks the timeout.
    always_comb begin
        ack       = req_q & mem.bus_ack_i;
        timeout   = WD_EN && req_q && !mem.bus_ack_i && (cnt_q == CNT_LAST);
        xfer_done = ack | timeout;
        cnt_inc   = (WD_EN && !xfer_done) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves one unassigned (no latches).
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        instr_d = instr_q;
        load_d  = load_q;
        ready_d = 1'b0;
        err_d   = err_q | timeout;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                // Both result latches restart at zero, so a latch not written in this step reads 0.
                instr_d = '0;
                load_d  = '0;
                cnt_d   = '0;
                if (mem.data_mem_wr_i) begin
                    state_d = ST_DATA;
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = mem.data_mem_addr_i;
                    wdata_d = mem.data_mem_data_i;
                end else if (mem.data_mem_rd_i) begin
                    state_d = ST_DATA;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = mem.data_mem_addr_i;
                    wdata_d = '0;
                end else if (mem.instr_mem_rd_i) begin
                    state_d = ST_INSTR;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = mem.instr_mem_addr_i;
                    wdata_d = '0;
                end else begin
                    state_d = ST_DONE;
                    ready_d = 1'b1;
                end
            end

            ST_DATA: begin
                if (xfer_done) begin
                    if (!we_q) begin
                        load_d = timeout ? '0 : mem.bus_rdata_i;
                    end
                    cnt_d = '0;
                    if (mem.instr_mem_rd_i) begin
                        state_d = ST_INSTR;
                        req_d   = 1'b1;
                        we_d    = 1'b0;
                        addr_d  = mem.instr_mem_addr_i;
                        wdata_d = '0;
                    end else begin
                        state_d = ST_DONE;
                        req_d   = 1'b0;
                        we_d    = 1'b0;
                        addr_d  = '0;
                        wdata_d = '0;
                        ready_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            ST_INSTR: begin
                if (xfer_done) begin
                    instr_d = timeout ? NOP_INSN : mem.bus_rdata_i;
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = '0;
                    wdata_d = '0;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                we_d    = 1'b0;
                addr_d  = '0;
                wdata_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            instr_q <= '0;
            load_q  <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            instr_q <= instr_d;
            load_q  <= load_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Both readies come from one flop: the core derives instr_mem_rd from data_mem_ready.
    assign mem.instr_mem_ready_o = ready_q;
    assign mem.data_mem_ready_o  = ready_q;
    assign mem.instr_mem_data_o  = instr_q;
    assign mem.data_mem_data_o   = load_q;
    assign mem.bus_req_o         = req_q;
    assign mem.bus_we_o          = we_q;
    assign mem.bus_addr_o        = addr_q;
    assign mem.bus_wdata_o       = wdata_q;
    assign mem.err_o             = err_q;

endmodule
